pe_uop_sequencer: RTL and testbench



---
 rtl/pe_uop_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pe_uop_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_uop_sequencer.sv
// pe_uop_sequencer: job controller streaming MAC/bias/flush uops into one PE and returning its result; define PE_SEQ_TIMEOUT_EN to bound WAIT_RES by TIMEOUT cycles
module pe_uop_sequencer #(
    parameter int XLEN    = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic [XLEN-1:0]  job_bias,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [XLEN-1:0]  op_x,
    input  logic [XLEN-1:0]  op_w,
    output logic [XLEN-1:0]  pe_x,
    output logic [XLEN-1:0]  pe_weight,
    output logic             pe_in_valid,
    output logic             pe_calc_bias,
    output logic             pe_out_en,
    output logic             pe_flush,
    input  logic [XLEN-1:0]  pe_result_r,
    input  logic             pe_out_valid_r,
    input  logic             pe_illegal_uop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic             res_err,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, MAC, BIAS, FLUSH, WAIT_RES, RESULT} state_t;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [XLEN-1:0]  bias_q, bias_d, data_q, data_d, x_q, x_d, w_q, w_d;
    logic             cap_q, cap_d, err_q, err_d;
    logic             iv_q, iv_d, cb_q, cb_d, oe_q, oe_d, fl_q, fl_d;
    logic             job_ready_q, op_ready_q, busy_q, res_valid_q;
    logic             tmo_hit;
`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    assign tmo_hit = state_q == WAIT_RES && !cap_q && !pe_out_valid_r && tmo_q == TW'(TIMEOUT - 1);
    // count cycles spent in WAIT_RES, restarting on every entry
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= state_q == WAIT_RES ? tmo_q + 1'b1 : '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif
    // next-state, capture, sticky error and next uop selection
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bias_d  = bias_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        err_d   = err_q | (state_q != IDLE && state_q != RESULT && pe_illegal_uop);
        iv_d    = 1'b0;
        cb_d    = 1'b0;
        oe_d    = 1'b0;
        fl_d    = 1'b0;
        x_d     = '0;
        w_d     = '0;
        if ((state_q == FLUSH || state_q == WAIT_RES) && !cap_q && pe_out_valid_r) begin
            cap_d  = 1'b1;
            data_d = pe_result_r;
        end
        case (state_q)
            IDLE: if (job_valid) begin
                len_d   = job_len;
                bias_d  = job_bias;
                cnt_d   = '0;
                cap_d   = 1'b0;
                err_d   = 1'b0;
                data_d  = '0;
                state_d = job_len == '0 ? BIAS : MAC;
            end
            MAC: if (op_valid) begin
                iv_d    = 1'b1;
                x_d     = op_x;
                w_d     = op_w;
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == len_q - 1'b1 ? BIAS : MAC;
            end
            BIAS: begin
                iv_d    = 1'b1;
                cb_d    = 1'b1;
                oe_d    = 1'b1;
                x_d     = bias_q;
                w_d     = XLEN'(1);
                state_d = FLUSH;
            end
            FLUSH: begin
                fl_d    = 1'b1;
                state_d = WAIT_RES;
            end
            WAIT_RES: if (cap_q || pe_out_valid_r || tmo_hit) begin
                state_d = RESULT;
                err_d   = err_d | tmo_hit;
            end
            RESULT: state_d = res_ready ? IDLE : RESULT;
            default: state_d = IDLE;
        endcase
    end
    // single FSM register with all outputs registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            bias_q      <= '0;
            cnt_q       <= '0;
            cap_q       <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            iv_q        <= 1'b0;
            cb_q        <= 1'b0;
            oe_q        <= 1'b0;
            fl_q        <= 1'b0;
            x_q         <= '0;
            w_q         <= '0;
            job_ready_q <= 1'b0;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bias_q      <= bias_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            data_q      <= data_d;
            err_q       <= err_d;
            iv_q        <= iv_d;
            cb_q        <= cb_d;
            oe_q        <= oe_d;
            fl_q        <= fl_d;
            x_q         <= x_d;
            w_q         <= w_d;
            job_ready_q <= state_d == IDLE;
            op_ready_q  <= state_d == MAC;
            busy_q      <= state_d != IDLE;
            res_valid_q <= state_d == RESULT;
        end
    end
    assign job_ready    = job_ready_q;
    assign op_ready     = op_ready_q;
    assign busy         = busy_q;
    assign res_valid    = res_valid_q;
    assign res_data     = data_q;
    assign res_err      = err_q;
    assign pe_x         = x_q;
    assign pe_weight    = w_q;
    assign pe_in_valid  = iv_q;
    assign pe_calc_bias = cb_q;
    assign pe_out_en    = oe_q;
    assign pe_flush     = fl_q;
endmodule

// File: tb/tb_pe_uop_sequencer.sv
// tb_pe_uop_sequencer: scoreboard bench with a PE stub for pe_uop_sequencer
module tb_pe_uop_sequencer;
    localparam int XLEN = 32, LEN_W = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic job_valid = 1'b0, job_ready, op_valid = 1'b0, op_ready;
    logic [LEN_W-1:0] job_len = '0;
    logic [XLEN-1:0] job_bias = '0, op_x = '0, op_w = '0, pe_x, pe_weight;
    logic pe_in_valid, pe_calc_bias, pe_out_en, pe_flush;
    logic [XLEN-1:0] pe_result_r = '0, res_data;
    logic pe_out_valid_r = 1'b0, pe_illegal_uop = 1'b0;
    logic res_valid, res_ready = 1'b0, res_err, busy;
    int errors = 0, checks = 0, cyc = 0;
    logic [XLEN-1:0] sb_d[$];
    logic sb_e[$];
    int mac_n, bias_n, fl_n, bad_n, gap_n, mac_at_bias, dly;
    bit seen_mac, stub_en = 1'b1;
    logic [XLEN-1:0] acc, res_val, bias_x;

    pe_uop_sequencer dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_len(job_len), .job_bias(job_bias), .op_valid(op_valid), .op_ready(op_ready),
        .op_x(op_x), .op_w(op_w), .pe_x(pe_x), .pe_weight(pe_weight),
        .pe_in_valid(pe_in_valid), .pe_calc_bias(pe_calc_bias), .pe_out_en(pe_out_en),
        .pe_flush(pe_flush), .pe_result_r(pe_result_r), .pe_out_valid_r(pe_out_valid_r),
        .pe_illegal_uop(pe_illegal_uop), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // PE stub: accumulates MACs, forms sum+bias on the bias uop, returns it two cycles after flush
    // followed by a spurious pulse that must be ignored; also classifies every uop on the pins
    always @(negedge clk) begin
        pe_out_valid_r = stub_en && (dly == 2 || dly == 1);
        pe_result_r = !stub_en ? 32'hDEADBEEF : dly == 2 ? res_val : dly == 1 ? res_val + 1 : 32'hDEADBEEF;
        if (dly > 0) dly--;
        if (rst || (job_valid && job_ready)) begin
            mac_n = 0; bias_n = 0; fl_n = 0; bad_n = 0; gap_n = 0; mac_at_bias = -1;
            seen_mac = 1'b0; acc = '0; bias_x = 'x;
            if (rst) dly = 0;
        end else if (pe_in_valid && !pe_calc_bias && !pe_out_en && !pe_flush) begin
            mac_n++; acc += pe_x * pe_weight; seen_mac = 1'b1;
        end else if (pe_in_valid && pe_calc_bias && pe_out_en && !pe_flush) begin
            bias_n++; mac_at_bias = mac_n; bias_x = pe_x; res_val = acc + pe_x * pe_weight; acc = '0;
        end else if (pe_flush && !pe_in_valid && !pe_calc_bias && !pe_out_en) begin
            fl_n++; dly = 3;
        end else if (pe_in_valid || pe_calc_bias || pe_out_en || pe_flush) begin
            bad_n++;
        end else if (seen_mac && bias_n == 0) begin
            gap_n++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_job(input string nm, input int n, input logic [XLEN-1:0] bias, input bit rnd,
                           input bit tog, input int ill, input int hold, input int lat, input bit tmo);
        logic [XLEN-1:0] expv, x, w, ed;
        logic ee;
        int i, c, t0, g;
        expv = bias;
        g = 0;
        while (!job_ready && g < 50) begin tick(); g++; end
        checks++;
        if (job_ready !== 1'b1) begin errors++; $display("FAIL %s job_ready act=%b req=1", nm, job_ready); end
        job_valid = 1'b1; job_len = LEN_W'(n); job_bias = bias; t0 = cyc;
        tick();
        job_valid = 1'b0;
        i = 0; c = 0;
        while (i < n && c < 4 * n + 20) begin
            op_valid = tog ? (c % 2 == 0) : 1'b1;
            x = rnd ? 32'($urandom_range(20)) - 32'd10 : 32'd1;
            w = rnd ? 32'($urandom_range(20)) - 32'd10 : 32'd1;
            op_x = x; op_w = w;
            pe_illegal_uop = op_valid && i == ill;
            if (op_valid && op_ready) begin expv += x * w; i++; end
            tick(); c++;
        end
        op_valid = 1'b0; pe_illegal_uop = 1'b0;
        sb_d.push_back(tmo ? '0 : expv);
        sb_e.push_back(tmo || ill >= 0);
        checks++;
        if (i != n) begin errors++; $display("FAIL %s beats act=%0d req=%0d", nm, i, n); end
        g = 0;
        while (!res_valid && g < 200) begin tick(); g++; end
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL %s res_valid_timeout act=%b req=1", nm, res_valid); end
        if (lat > 0) begin
            checks++;
            if (cyc - t0 != lat) begin errors++; $display("FAIL %s latency act=%0d req=%0d", nm, cyc - t0, lat); end
        end
        ed = sb_d.pop_front(); ee = sb_e.pop_front();
        checks++;
        if (res_data !== ed || res_err !== ee) begin
            errors++; $display("FAIL %s result act=%h/%b req=%h/%b", nm, res_data, res_err, ed, ee);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== ed || res_err !== ee || job_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d act=%b/%h/%b/%b req=1/%h/%b/0", nm, k, res_valid, res_data, res_err, job_ready, ed, ee);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s release act=%b/%b/%b req=0/1/0", nm, res_valid, job_ready, busy);
        end
        checks++;
        if (mac_n != n || bias_n != 1 || fl_n != 1 || bad_n != 0 || mac_at_bias != n || bias_x !== bias) begin
            errors++;
            $display("FAIL %s uops act=mac%0d bias%0d fl%0d bad%0d at%0d bx%h req=mac%0d bias1 fl1 bad0 at%0d bx%h",
                     nm, mac_n, bias_n, fl_n, bad_n, mac_at_bias, bias_x, n, n, bias);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({job_ready, op_ready, busy, res_valid, res_err, pe_in_valid, pe_calc_bias, pe_out_en, pe_flush} !== 9'b0 || res_data !== '0) begin
            errors++; $display("FAIL reset_outputs act=%b%b%b%b%b%b%b%b%b/%h req=0", job_ready, op_ready, busy,
                               res_valid, res_err, pe_in_valid, pe_calc_bias, pe_out_en, pe_flush, res_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release act=%b/%b req=1/0", job_ready, busy); end
    endtask

    task automatic test_basic();
        run_job("n32", 32, 32'd0, 1'b0, 1'b0, -1, 0, 38, 1'b0);
    endtask

    task automatic test_toggle();
        run_job("tog4", 4, 32'd7, 1'b1, 1'b1, -1, 0, 0, 1'b0);
        checks++;
        if (gap_n != 3) begin errors++; $display("FAIL tog4 idle_gaps act=%0d req=3", gap_n); end
    endtask

    task automatic test_zero_len();
        run_job("n0", 0, 32'hFFFFFFFB, 1'b0, 1'b0, -1, 0, 6, 1'b0);
    endtask

    task automatic test_illegal();
        run_job("ill", 8, 32'd3, 1'b1, 1'b0, 2, 0, 14, 1'b0);
        run_job("after_ill", 8, 32'd3, 1'b1, 1'b0, -1, 0, 14, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job("hold", 5, 32'd100, 1'b1, 1'b0, -1, 10, 11, 1'b0);
        run_job("b2b", 3, 32'hFFFFFF00, 1'b1, 1'b0, -1, 0, 9, 1'b0);
    endtask

    task automatic test_max_len();
        run_job("max", 65535, 32'd0, 1'b0, 1'b0, -1, 0, 65541, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        job_valid = 1'b1; job_len = 16'd8; job_bias = 32'd9;
        tick();
        job_valid = 1'b0; op_valid = 1'b1; op_x = 32'd2; op_w = 32'd3;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        op_valid = 1'b0;
        checks++;
        if ({job_ready, op_ready, busy, res_valid, pe_in_valid, pe_calc_bias, pe_out_en, pe_flush} !== 8'b0) begin
            errors++; $display("FAIL mid_reset act=%b%b%b%b%b%b%b%b req=0", job_ready, op_ready, busy, res_valid,
                               pe_in_valid, pe_calc_bias, pe_out_en, pe_flush);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin tick(); seen |= res_valid; end
        checks++;
        if (seen || mac_n != 0 || bias_n != 0 || fl_n != 0 || bad_n != 0) begin
            errors++; $display("FAIL mid_reset_quiet act=res%b mac%0d bias%0d fl%0d req=res0 mac0 bias0 fl0", seen, mac_n, bias_n, fl_n);
        end
        run_job("post_reset", 2, 32'd1, 1'b1, 1'b0, -1, 0, 8, 1'b0);
    endtask

`ifdef PE_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        stub_en = 1'b0;
        run_job("tmo", 2, 32'd5, 1'b0, 1'b0, -1, 0, 69, 1'b1);
        stub_en = 1'b1;
        run_job("after_tmo", 2, 32'd5, 1'b0, 1'b0, -1, 0, 8, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_zero_len();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef PE_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
